// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Digit indices and common-anode hex font for the 7-seg scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam logic [1:0] DIG0 = 2'd0;
  localparam logic [1:0] DIG1 = 2'd1;
  localparam logic [1:0] DIG2 = 2'd2;
  localparam logic [1:0] DIG3 = 2'd3;

  // Active-low segments, bit 0 = CA ... bit 6 = CG
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = SEG_0;
      4'h1:    hex_to_seg = SEG_1;
      4'h2:    hex_to_seg = SEG_2;
      4'h3:    hex_to_seg = SEG_3;
      4'h4:    hex_to_seg = SEG_4;
      4'h5:    hex_to_seg = SEG_5;
      4'h6:    hex_to_seg = SEG_6;
      4'h7:    hex_to_seg = SEG_7;
      4'h8:    hex_to_seg = SEG_8;
      4'h9:    hex_to_seg = SEG_9;
      4'hA:    hex_to_seg = SEG_A;
      4'hB:    hex_to_seg = SEG_B;
      4'hC:    hex_to_seg = SEG_C;
      4'hD:    hex_to_seg = SEG_D;
      4'hE:    hex_to_seg = SEG_E;
      default: hex_to_seg = SEG_F;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
// ============================================================================
// Module      : seg7_hex_decoder
// Description : Combinational nibble to active-low segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nibble);

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : 4-digit 7-seg scanner with shadow/live registers that commit
//               only at frame wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DWELL = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending,
  output logic        frame_done,
  output logic        committed
);

  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_dig;
  logic [15:0]   r_sh_val, r_lv_val;
  logic [3:0]    r_sh_dp, r_lv_dp;
  logic [3:0]    r_sh_blank, r_lv_blank;
  logic          r_pending, r_frame_done, r_committed;

  logic w_adv, w_wrap;
  logic [3:0] w_nibble;

  assign w_adv  = (r_cnt == CW'(DWELL - 1));
  assign w_wrap = w_adv && (r_dig == DIG0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_dig        <= DIG3;
      r_sh_val     <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '0;
      r_lv_val     <= '0;
      r_lv_dp      <= '0;
      r_lv_blank   <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_committed  <= 1'b0;
    end else begin
      r_cnt        <= w_adv ? '0 : r_cnt + 1'b1;
      r_frame_done <= w_wrap;
      r_committed  <= w_wrap && r_pending;
      if (w_adv)
        r_dig <= r_dig - 2'd1;
      // Live takes the pre-edge shadow, so a colliding load lands next frame
      if (w_wrap && r_pending) begin
        r_lv_val   <= r_sh_val;
        r_lv_dp    <= r_sh_dp;
        r_lv_blank <= r_sh_blank;
      end
      if (load) begin
        r_sh_val   <= value;
        r_sh_dp    <= dp_mask;
        r_sh_blank <= blank_mask;
        r_pending  <= 1'b1;
      end else if (w_wrap) begin
        r_pending  <= 1'b0;
      end
    end
  end

  assign w_nibble = r_lv_val[{r_dig, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .i_nibble (w_nibble),
    .o_seg    (seg)
  );

  assign an         = r_lv_blank[r_dig] ? 4'b1111 : ~(4'b0001 << r_dig);
  assign dp         = ~r_lv_dp[r_dig];
  assign pending    = r_pending;
  assign frame_done = r_frame_done;
  assign committed  = r_committed;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Directed bench for seg7_scan_ctrl with DWELL=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp, pending, frame_done, committed;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;   // edges since reset release

  seg7_scan_ctrl #(.DWELL(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .pending    (pending),
    .frame_done (frame_done),
    .committed  (committed)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] an_slot(input int tt);
    logic [3:0] seq [4];
    seq = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    return seq[(tt / 4) % 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    t = 0;
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (an !== 4'b0111 || seg !== 7'b1000000 || dp !== 1'b1 || pending !== 1'b0 ||
        frame_done !== 1'b0 || committed !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: an=%b seg=%b dp=%b pend=%b fd=%b cm=%b, want 0111 1000000 1 0 0 0",
               an, seg, dp, pending, frame_done, committed);
    end
    run_to(3);
    n_checks++;
    if (an !== 4'b0111) begin
      n_errors++;
      $display("FAIL reset_hold3: an=%b want 0111", an);
    end
    run_to(4);
    n_checks++;
    if (an !== 4'b1011) begin
      n_errors++;
      $display("FAIL reset_first_adv: an=%b want 1011", an);
    end
  endtask

  task automatic test_scan();
    logic fd_exp;
    do_reset();
    while (t < 40) begin
      tick();
      fd_exp = (t % 16 == 0);
      n_checks++;
      if (an !== an_slot(t) || frame_done !== fd_exp) begin
        n_errors++;
        $display("FAIL scan t=%0d: an=%b fd=%b, want an=%b fd=%b", t, an, frame_done, an_slot(t), fd_exp);
      end
    end
  endtask

  task automatic test_deferred_commit();
    do_reset();
    run_to(5);
    value = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (pending !== 1'b1 || an !== 4'b1011 || seg !== 7'b1000000) begin
      n_errors++;
      $display("FAIL defer_pending: pend=%b an=%b seg=%b, want 1 1011 1000000", pending, an, seg);
    end
    run_to(15);
    n_checks++;
    if (committed !== 1'b0 || seg !== 7'b1000000 || pending !== 1'b1) begin
      n_errors++;
      $display("FAIL defer_prewrap: cm=%b seg=%b pend=%b, want 0 1000000 1", committed, seg, pending);
    end
    run_to(16);
    n_checks++;
    if (committed !== 1'b1 || pending !== 1'b0 || an !== 4'b0111 || seg !== 7'b1111001) begin
      n_errors++;
      $display("FAIL defer_commit: cm=%b pend=%b an=%b seg=%b, want 1 0 0111 1111001",
               committed, pending, an, seg);
    end
    run_to(17);
    n_checks++;
    if (committed !== 1'b0) begin
      n_errors++;
      $display("FAIL defer_pulse_width: cm=%b want 0", committed);
    end
    run_to(20);
    n_checks++;
    if (an !== 4'b1011 || seg !== 7'b0100100) begin
      n_errors++;
      $display("FAIL defer_dig2: an=%b seg=%b want 1011 0100100", an, seg);
    end
    run_to(24);
    n_checks++;
    if (an !== 4'b1101 || seg !== 7'b0110000) begin
      n_errors++;
      $display("FAIL defer_dig1: an=%b seg=%b want 1101 0110000", an, seg);
    end
    run_to(28);
    n_checks++;
    if (an !== 4'b1110 || seg !== 7'b0011001) begin
      n_errors++;
      $display("FAIL defer_dig0: an=%b seg=%b want 1110 0011001", an, seg);
    end
  endtask

  task automatic test_collision();
    do_reset();
    run_to(2);
    value = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    run_to(15);
    value = 16'hABCD; load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (committed !== 1'b1 || pending !== 1'b1 || seg !== 7'b1111001) begin
      n_errors++;
      $display("FAIL collide_commit: cm=%b pend=%b seg=%b, want 1 1 1111001", committed, pending, seg);
    end
    run_to(20);
    n_checks++;
    if (seg !== 7'b0100100 || pending !== 1'b1) begin
      n_errors++;
      $display("FAIL collide_live_old: seg=%b pend=%b want 0100100 1", seg, pending);
    end
    run_to(32);
    n_checks++;
    if (committed !== 1'b1 || pending !== 1'b0 || an !== 4'b0111 || seg !== 7'b0001000) begin
      n_errors++;
      $display("FAIL collide_second: cm=%b pend=%b an=%b seg=%b, want 1 0 0111 0001000",
               committed, pending, an, seg);
    end
  endtask

  task automatic test_masks();
    logic [3:0] an_e;
    logic       dp_e;
    do_reset();
    run_to(2);
    value = 16'h8888; dp_mask = 4'b0100; blank_mask = 4'b0001; load = 1'b1;
    tick();
    load = 1'b0; dp_mask = 4'b0000; blank_mask = 4'b0000;
    run_to(15);
    while (t < 33) begin
      tick();
      an_e = (t >= 28 && t < 32) ? 4'b1111 : an_slot(t);
      dp_e = !(t >= 20 && t < 24);
      n_checks++;
      if (an !== an_e || dp !== dp_e || seg !== 7'b0000000) begin
        n_errors++;
        $display("FAIL masks t=%0d: an=%b dp=%b seg=%b, want %b %b 0000000", t, an, dp, seg, an_e, dp_e);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_to(2);
    value = 16'hFFFF; load = 1'b1;
    tick();
    load = 1'b0;
    run_to(8);
    reset = 1'b1;
    tick();
    n_checks++;
    if (pending !== 1'b0 || committed !== 1'b0 || an !== 4'b0111 || seg !== 7'b1000000 || dp !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_state: pend=%b cm=%b an=%b seg=%b dp=%b", pending, committed, an, seg, dp);
    end
    reset = 1'b0;
    t = 0;
    while (t < 20) begin
      tick();
      n_checks++;
      if (committed !== 1'b0 || pending !== 1'b0 || seg !== 7'b1000000 || an !== an_slot(t)) begin
        n_errors++;
        $display("FAIL midreset_after t=%0d: cm=%b pend=%b seg=%b an=%b want 0 0 1000000 %b",
                 t, committed, pending, seg, an, an_slot(t));
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_deferred_commit();
    test_collision();
    test_masks();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Scan controller for the board's 4-digit, common-anode seven-segment display. It accepts a 16-bit hex value plus per-digit decimal-point and blanking masks through a load handshake, and holds them in a shadow register. It commits the shadow to the live display only at a frame boundary, so a frame never shows a mix of old and new digits. It time-multiplexes the four anodes at a programmable dwell rate and sits between the application logic and the AN0..AN3 / CA..CG / DP pins.

## Interface
- DWELL, 65536: clock cycles each digit stays active; legal range 2..2^20.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  single-cycle write strobe; value and masks are sampled when it is high.
- value  in  16  hex digits: [15:12] goes to AN3, [11:8] to AN2, [7:4] to AN1, [3:0] to AN0.
- dp_mask  in  4  decimal point on when the bit is 1; bit i maps to ANi.
- blank_mask  in  4  digit dark when the bit is 1; bit i maps to ANi.
- an  out  4  anode enables, active-low; an[i] drives ANi.
- seg  out  7  segments, active-low; seg[0]=CA … seg[6]=CG.
- dp  out  1  decimal point, active-low.
- pending  out  1  shadow holds a load that has not been committed yet.
- frame_done  out  1  one-cycle pulse at every frame wrap.
- committed  out  1  one-cycle pulse when the shadow is copied to live.

## Operation
- Dwell counter cnt: width is clog2(DWELL). It counts 0..DWELL-1 and wraps to 0. A digit advance happens in the cycle where cnt==DWELL-1.
- Digit index dig: 2 bits, scan order 3→2→1→0→3. State is dig alone; there is no other FSM.
- Frame wrap: a digit advance with dig==0. On that edge dig becomes 3 and frame_done is asserted for one cycle.
- Shadow registers: sh_val[15:0], sh_dp[3:0], sh_blank[3:0].
  - Written on every load, whether or not pending is set; the last load wins.
  - pending is set by load.
- Live registers: lv_val, lv_dp, lv_blank.
  - On a frame wrap with pending==1, live ← shadow, pending is cleared and committed pulses for one cycle.
- Load on the same edge as a commit:
  - The commit takes the old shadow.
  - The shadow takes the new data.
  - pending stays 1; the new data commits at the next wrap.
- Output decode, combinational from registered state:
  - an = one-hot-low of dig, forced to all 1 when lv_blank[dig]==1.
  - seg = hex font of lv_val nibble dig (0-F; b and d lower-case).
  - dp = ~lv_dp[dig].
- Hex font, seg[6:0]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Reset values:
  - Internal state: cnt=0, dig=3, all shadow and live registers 0, pending=0.
  - Outputs: an=0111, seg=1000000, dp=1, frame_done=0, committed=0.
- Reset asserted mid-frame:
  - Takes effect on the next edge.
  - Discards pending data and the live contents.
  - Display shows '0' on AN3 in the following cycle.
- Digit period is exactly DWELL cycles; frame period is 4·DWELL cycles.
- After reset, the first advance (3→2) occurs on the DWELL-th edge.
- Load latency:
  - pending is high the cycle after the load edge.
  - Commit happens at the next frame wrap, i.e. within 4·DWELL cycles.
  - New digits are visible on an/seg in the cycle after the commit edge.
- frame_done, committed and the dig change all take effect on the same edge; the decode follows in the same cycle.
- load is accepted every cycle; there is no back-pressure.

## Structure
- Package seg7_pkg holds:
  - localparams DIG0..DIG3 (digit index values 0..3);
  - the SEG_* font constants;
  - function hex_to_seg(input [3:0]) returning [6:0].
- Sub-module seg7_hex_decoder: combinational nibble→seg wrapper around hex_to_seg, instantiated once on the muxed nibble.
- Top-level seg7_scan_ctrl holds the counter, digit index, shadow/live registers and output mux.

## Test plan
Run with DWELL=4.
- Reset: hold reset 3 cycles and release → an=0111, seg=1000000, dp=1, pending=0. The first an change to 1011 occurs 4 cycles after release.
- Scan cadence: free run 40 cycles → an sequence 0111, 1011, 1101, 1110, each held 4 cycles. frame_done pulses every 16 cycles, aligned with the 1110→0111 transition.
- Deferred commit: load value=16'h1234 while dig=2 → pending=1 and the display keeps showing 0s. At the wrap, committed pulses and pending drops to 0. Next cycle an=0111 with seg=1111001, then 0100100, 0110000, 0011001.
- Collision: load 16'hABCD on the exact wrap edge that commits a pending 16'h1234 → live shows 1234 and pending stays 1. ABCD commits at the following wrap; AN3 then shows seg=0001000.
- Masks: load value=16'h8888, dp_mask=0100, blank_mask=0001 → after commit, dp=0 only while an=1011. an stays 1111 during the AN0 slot, and the slot still lasts 4 cycles.
- Reset mid-operation: load 16'hFFFF, then assert reset before the wrap → pending=0, no committed pulse, and the display returns to the reset values.
